montgomery_precompute: RTL
==========================

MONTGOMERY_PRECOMPUTE -- requirements
Module: montgomery_precompute

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: modulus and result width; legal values 8-64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: start request, sampled only in IDLE.
REQ-005 SHALL have port m, input, WORD_WIDTH bits: modulus, sampled on the accepting edge.
REQ-006 SHALL have port busy, output, 1 bit: high while the state is RUN.
REQ-007 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port err, output, 1 bit: modulus illegal, valid while done is high and held until the next accepted start.
REQ-009 SHALL have port r_mod_m, output, WORD_WIDTH bits: 2^WORD_WIDTH mod m.
REQ-010 SHALL have port r2_mod_m, output, WORD_WIDTH bits: 2^(2*WORD_WIDTH) mod m.
REQ-011 SHALL have port m_prime, output, WORD_WIDTH bits: -m^-1 mod 2^WORD_WIDTH.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with enable=1, latch m into an internal register and clear err.
REQ-014 SHALL, after that latch, go to DONE with err=1 and all result outputs 0 when m is even or m==1; RUN is skipped.
REQ-015 SHALL otherwise initialise v=1 (WORD_WIDTH+1 bits), y=1, t=m, cnt=0, and go to RUN.
REQ-016 SHALL, on each RUN cycle, replace v with 2v, then subtract m once if 2v>=m; comparison is at WORD_WIDTH+1 bits and v<m always holds.
REQ-017 SHALL, in the same RUN cycle and only when cnt<WORD_WIDTH-1, take i=cnt+1 and, if t[i]==1, set y[i]=1 and t=t+(m<<i) mod 2^WORD_WIDTH.
REQ-018 SHALL capture the updated v into r_mod_m in the RUN cycle where cnt==WORD_WIDTH-1.
REQ-019 SHALL, in the RUN cycle where cnt==2*WORD_WIDTH-1:
- load r2_mod_m from the updated v;
- load m_prime with (~y+1) mod 2^WORD_WIDTH;
- go to DONE.
REQ-020 SHALL give a legal run a latency of exactly 2*WORD_WIDTH+1 rising edges from the accepting edge to the edge where done rises.
REQ-021 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL ignore enable while in RUN or DONE; no queuing.
REQ-023 SHALL hold r_mod_m, r2_mod_m, m_prime and err stable from DONE until the next accepted start.
REQ-024 SHALL let r_mod_m change mid-run but not be consumed before done.
REQ-025 SHALL ignore changes on m after the accepting edge.
REQ-026 SHALL accept enable held high continuously again in the IDLE cycle after DONE, giving back-to-back runs.

Reset
REQ-027 SHALL, on reset low at any time including mid-RUN:
- enter IDLE immediately;
- force busy=0, done=0, err=0;
- force r_mod_m, r2_mod_m, m_prime and all internal registers to 0.
REQ-028 SHALL accept no start until reset is deasserted; the first accepted edge is the first rising edge with reset=1 and enable=1.

Verification (WORD_WIDTH=32)
REQ-029 SHALL pass this check: m=0xFFFFFFFB, one-cycle enable -> done exactly 65 edges later, err=0, r_mod_m=5, r2_mod_m=25, m_prime=0xCCCCCCCD.
REQ-030 SHALL pass this check: m=3 -> r_mod_m=1, r2_mod_m=1, m_prime=0x55555555, err=0.
REQ-031 SHALL pass this check: m=10, then m=1 -> done one edge after acceptance, err=1, all results 0, busy never high.
REQ-032 SHALL pass this check: start m=0xFFFFFFFB, pulse enable with m=3 at cnt=10 -> the second pulse is ignored and the results equal those of REQ-029.
REQ-033 SHALL pass this check: assert reset at cnt=40 -> outputs 0 and state IDLE at once; a new start with m=3 then yields the REQ-030 results.
REQ-034 SHALL pass this check: 1000 random odd m>1, results compared against a reference model -> full match; every resulting triple, fed with random x and e to the downstream montgomery_exp, gives x^e mod m.

Source files
------------

// File: rtl/montgomery_precompute.sv
// Montgomery constant generator: for an odd modulus m computes R mod m, R^2 mod m
// and -m^-1 mod R (R = 2^WORD_WIDTH) with a bit-serial shift/subtract and Hensel lift.
module montgomery_precompute #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] m,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WORD_WIDTH-1:0] r_mod_m,
    output logic [WORD_WIDTH-1:0] r2_mod_m,
    output logic [WORD_WIDTH-1:0] m_prime
);
    localparam int CW = $clog2(2 * WORD_WIDTH);
    localparam logic [CW-1:0] LAST_R  = CW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0] LAST_R2 = CW'(2 * WORD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [WORD_WIDTH-1:0] m_reg;
    logic [WORD_WIDTH:0]   v_reg;
    logic [WORD_WIDTH-1:0] y_reg, t_reg;
    logic [CW-1:0]         cnt_reg;

    logic                  m_legal;
    logic [WORD_WIDTH:0]   v_dbl, v_step;
    logic [CW-1:0]         idx;
    logic [WORD_WIDTH-1:0] t_shift, y_step, t_step;

    assign m_legal = m[0] && (m != WORD_WIDTH'(1));
    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = m_legal ? RUN : DONE;
            RUN:     if (cnt_reg == LAST_R2) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // v < m always, so doubling fits in WORD_WIDTH+1 bits and one subtraction reduces it.
    always_comb begin
        v_dbl   = v_reg << 1;
        v_step  = (v_dbl >= {1'b0, m_reg}) ? v_dbl - {1'b0, m_reg} : v_dbl;
        idx     = cnt_reg + CW'(1);
        t_shift = t_reg >> idx;
        y_step  = y_reg;
        t_step  = t_reg;
        // Hensel lift: keep t = m*y mod R and clear bit idx of t by setting bit idx of y.
        if (cnt_reg < LAST_R && t_shift[0]) begin
            y_step = y_reg | (WORD_WIDTH'(1) << idx);
            t_step = t_reg + (m_reg << idx);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg    <= '0;
            v_reg    <= '0;
            y_reg    <= '0;
            t_reg    <= '0;
            cnt_reg  <= '0;
            err      <= 1'b0;
            r_mod_m  <= '0;
            r2_mod_m <= '0;
            m_prime  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        m_reg <= m;
                        err   <= ~m_legal;
                        if (m_legal) begin
                            v_reg   <= (WORD_WIDTH + 1)'(1);
                            y_reg   <= WORD_WIDTH'(1);
                            t_reg   <= m;
                            cnt_reg <= '0;
                        end else begin
                            r_mod_m  <= '0;
                            r2_mod_m <= '0;
                            m_prime  <= '0;
                        end
                    end
                end
                RUN: begin
                    v_reg   <= v_step;
                    y_reg   <= y_step;
                    t_reg   <= t_step;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_R)
                        r_mod_m <= v_step[WORD_WIDTH-1:0];
                    if (cnt_reg == LAST_R2) begin
                        r2_mod_m <= v_step[WORD_WIDTH-1:0];
                        m_prime  <= ~y_reg + WORD_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
